esfa_bench_sequencer: RTL

Parametrised benchmark sequencer that drives several ESFA design-under-test channels through a fixed number of start/done iterations. It checks every channel's per-iteration result and measures total run cycles. It reports a single pass/fail verdict plus per-channel failure diagnostics. It sits between the top-level run control (`doRun`/`isRunning`/`wasSuccessful`) and an array of DUT instances, generalising the single-channel benchmark harness with channel count, iteration count, timeout and stop-on-fail mode.

---
 rtl/esfa_bench_sequencer.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/esfa_bench_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : esfa_bench_sequencer
// Purpose  : Runs an array of ESFA DUT channels through ITERATIONS start/done
//            rounds. Checks each channel's result per round, counts the cycles
//            spent running and reports one verdict plus a sticky per-channel
//            failure mask.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk           in   rising-edge clock
//   reset         in   synchronous active-high reset
//   doRun         in   level run request; dropping it mid-run aborts the run
//   isRunning     out  high in LAUNCH, WAIT and CHECK
//   wasSuccessful out  verdict of the last completed run (valid with runDone)
//   runDone       out  set in DONE, held until the next run launches
//   aborted       out  last run ended because doRun fell
//   chStart       out  [NUM_CH] one-cycle start pulse to all channels
//   chDone        in   [NUM_CH] per-channel completion (pulse or level)
//   chOk          in   [NUM_CH] per-channel result, taken with first chDone
//   failMask      out  [NUM_CH] channels that failed in any round of the run
//   iterCount     out  rounds completed in the current or last run
//   cycleCount    out  [CYC_W] running cycles, saturating
// ============================================================================
module esfa_bench_sequencer #(
  parameter int NUM_CH       = 4,
  parameter int ITERATIONS   = 8,
  parameter int TIMEOUT      = 1024,
  parameter int CYC_W        = 32,
  parameter bit STOP_ON_FAIL = 1'b1
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              doRun,
  output logic                              isRunning,
  output logic                              wasSuccessful,
  output logic                              runDone,
  output logic                              aborted,
  output logic [NUM_CH-1:0]                 chStart,
  input  logic [NUM_CH-1:0]                 chDone,
  input  logic [NUM_CH-1:0]                 chOk,
  output logic [NUM_CH-1:0]                 failMask,
  output logic [$clog2(ITERATIONS+1)-1:0]   iterCount,
  output logic [CYC_W-1:0]                  cycleCount
);

  localparam int ITER_W = $clog2(ITERATIONS + 1);
  localparam int TMO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(ITERATIONS);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LAUNCH = 3'd1,
    ST_WAIT   = 3'd2,
    ST_CHECK  = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  state_t state, state_nx;

  logic [NUM_CH-1:0] done_lat;
  logic [NUM_CH-1:0] ok_lat;
  logic [TMO_W-1:0]  tmo_cnt;

  logic [NUM_CH-1:0] done_seen;
  logic [NUM_CH-1:0] first_done;
  logic [NUM_CH-1:0] fail_bits;
  logic [ITER_W-1:0] iter_inc;
  logic [CYC_W-1:0]  cyc_inc;
  logic              all_done;
  logic              tmo_hit;
  logic              stop_now;

  // A channel signalling done in the same cycle as the timeout still counts,
  // so the exit decision looks at the latches merged with this cycle's chDone.
  assign done_seen  = done_lat | chDone;
  assign first_done = chDone & ~done_lat;
  assign all_done   = &done_seen;
  assign tmo_hit    = (tmo_cnt == TMO_LAST);
  assign fail_bits  = ~done_lat | ~ok_lat;
  assign iter_inc   = iterCount + ITER_W'(1);
  assign stop_now   = (iter_inc == ITER_LAST) || (STOP_ON_FAIL && (|fail_bits));
  assign cyc_inc    = (cycleCount == '1) ? cycleCount : cycleCount + CYC_W'(1);

  always_comb begin
    state_nx  = state;
    isRunning = 1'b0;
    chStart   = '0;
    case (state)
      ST_IDLE: begin
        if (doRun) state_nx = ST_LAUNCH;
      end
      ST_LAUNCH: begin
        isRunning = 1'b1;
        chStart   = '1;
        state_nx  = doRun ? ST_WAIT : ST_DONE;
      end
      ST_WAIT: begin
        isRunning = 1'b1;
        if (!doRun)                    state_nx = ST_DONE;
        else if (all_done || tmo_hit)  state_nx = ST_CHECK;
      end
      ST_CHECK: begin
        isRunning = 1'b1;
        if (!doRun || stop_now) state_nx = ST_DONE;
        else                    state_nx = ST_LAUNCH;
      end
      ST_DONE: begin
        // Holding here while doRun stays high makes one request one run.
        if (!doRun) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      done_lat      <= '0;
      ok_lat        <= '0;
      tmo_cnt       <= '0;
      failMask      <= '0;
      iterCount     <= '0;
      cycleCount    <= '0;
      aborted       <= 1'b0;
      runDone       <= 1'b0;
      wasSuccessful <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        ST_IDLE: begin
          if (doRun) begin
            failMask      <= '0;
            iterCount     <= '0;
            cycleCount    <= '0;
            aborted       <= 1'b0;
            runDone       <= 1'b0;
            wasSuccessful <= 1'b0;
          end
        end
        ST_LAUNCH: begin
          // Latches clear here, so any chDone seen during LAUNCH is ignored.
          done_lat   <= '0;
          ok_lat     <= '0;
          tmo_cnt    <= '0;
          cycleCount <= cyc_inc;
          if (!doRun) aborted <= 1'b1;
        end
        ST_WAIT: begin
          cycleCount <= cyc_inc;
          if (!doRun) begin
            aborted <= 1'b1;
          end else begin
            done_lat <= done_seen;
            ok_lat   <= ok_lat | (chOk & first_done);
            tmo_cnt  <= tmo_cnt + TMO_W'(1);
          end
        end
        ST_CHECK: begin
          cycleCount <= cyc_inc;
          // An abort in CHECK discards the round being checked.
          if (!doRun) begin
            aborted <= 1'b1;
          end else begin
            failMask  <= failMask | fail_bits;
            iterCount <= iter_inc;
          end
        end
        ST_DONE: begin
          wasSuccessful <= (failMask == '0) && !aborted;
          runDone       <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire
